// File: rtl/instruction_fetch_unit.sv
// Zero-latency instruction fetch front end with a QDEPTH-entry fetch queue and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise sticky fetch_err and halt fetching.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_err
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;
    logic          halted;

    // Queue payload is not reset; occupancy alone decides what is valid.
    logic [31:0] pc_mem_q   [QDEPTH];
    logic [31:0] inst_mem_q [QDEPTH];

`ifdef FETCH_ALIGN_CHECK_EN
    logic halted_q, halted_d;
    assign halted    = halted_q;
    assign fetch_err = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign out_valid = (cnt_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];

    always_comb begin
        pop      = out_valid && out_ready;
        push     = !redirect_valid && !halted && ((cnt_q != CNT_FULL) || pop);
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                pc_d     = pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop) cnt_d = cnt_q + CNT_ONE;
            else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        // Sticky until reset; a later aligned redirect does not clear it.
        halted_d = halted_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
`ifdef FETCH_ALIGN_CHECK_EN
            halted_q <= halted_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= imem_dout;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table after reset, then redirect, wrap, reset and alignment cases.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_dout;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int n_pop = 0;
    logic sb_en = 1'b0;
    logic [31:0] sb_e;
    logic [31:0] exp_q[$];

    instruction_fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;

    // Word-addressed memory: word i holds 0x1000_0000 + i.
    assign imem_dout = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got pc %h expected none", out_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", out_pc, sb_e);
                chk("sb_inst", out_inst, inst_of(sb_e));
                n_pop++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vt[9];

    initial begin
        // Stall 5 cycles from reset, then drain: queue holds 0,4 and PC parks at 8.
        vt[0] = '{1'b0, 1'b0, 32'h0,  32'h0};
        vt[1] = '{1'b0, 1'b1, 32'h0,  32'h4};
        vt[2] = '{1'b0, 1'b1, 32'h0,  32'h8};
        vt[3] = '{1'b0, 1'b1, 32'h0,  32'h8};
        vt[4] = '{1'b0, 1'b1, 32'h0,  32'h8};
        vt[5] = '{1'b1, 1'b1, 32'h0,  32'h8};
        vt[6] = '{1'b1, 1'b1, 32'h4,  32'hC};
        vt[7] = '{1'b1, 1'b1, 32'h8,  32'h10};
        vt[8] = '{1'b1, 1'b1, 32'hC,  32'h14};

        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
`endif
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            out_ready = vt[i].rdy;
            if (i == 0) reset = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ev});
            chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].eaddr);
            if (vt[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), out_pc, vt[i].epc);
                chk($sformatf("tbl%0d_inst", i), out_inst, inst_of(vt[i].epc));
            end
        end

        // Redirect while full and draining: one empty cycle, then the target.
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_valid0", {31'b0, out_valid}, 32'h0);
        chk("rd_addr", imem_addr, 32'h40);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_valid1", {31'b0, out_valid}, 32'h1);
        chk("rd_pc", out_pc, 32'h40);
        chk("rd_inst", out_inst, 32'h1000_0010);

        // Scoreboard run across the 2^32 wrap with random backpressure.
        @(posedge clk); #1;
        sb_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(32'hFFFF_FFF0 + 32'(k * 4));
        sb_en = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        sb_en = 1'b0;
        chk("sb_min_pops", {31'b0, (n_pop >= 10)}, 32'h1);

        // Half-cycle reset pulse mid-stream.
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_valid", {31'b0, out_valid}, 32'h1);
        chk("restart_pc", out_pc, 32'h0);
        chk("restart_inst", out_inst, 32'h1000_0000);

        // Misaligned redirect target.
        out_ready = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_valid0", {31'b0, out_valid}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("mis_halt_valid%0d", c), {31'b0, out_valid}, 32'h0);
            chk($sformatf("mis_err%0d", c), {31'b0, fetch_err}, 32'h1);
        end
`else
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_valid1", {31'b0, out_valid}, 32'h1);
        chk("mis_pc", out_pc, 32'h42);
        chk("mis_inst", out_inst, 32'h1000_0010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
